mem_line_ctrl: RTL and testbench

- Parametrised main-memory controller/model serving cache-line reads and writes from N requester ports (I-cache, D-cache, …).
- Successor to the fixed single-delay memory constants: request delay, response delay, line width, depth and port count are all parameters.
- Round-robin arbitration across ports; one transaction in flight at a time.
- Sits below the L1 caches as the backing store for simulation and FPGA builds.

---
 rtl/mem_line_ctrl_pkg.sv | 24 ++
 rtl/mem_line_ctrl_rr_arbiter.sv | 52 +++++
 rtl/mem_line_ctrl.sv | 159 +++++++++++++++
 tb/tb_mem_line_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_line_ctrl_pkg.sv
// Shared constants and types for the cache-line backing-store controller.
package mem_line_ctrl_pkg;

  localparam int unsigned CACHE_LINE_LEN = 128;
  localparam int unsigned MEM_REQ_DELAY  = 5;
  localparam int unsigned MEM_RESP_DELAY = 5;
  localparam int unsigned MEM_LINES      = 1024;
  localparam int unsigned N_MEM_PORTS    = 2;
  localparam int unsigned MEM_ADDR_BITS  = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ_WAIT  = 3'd1,
    ACCESS    = 3'd2,
    RESP_WAIT = 3'd3,
    RESP      = 3'd4
  } mem_state_e;

  // Width of an index into n items; never zero so single-entry cases stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_line_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, pointer moves on handshake.
module mem_line_ctrl_rr_arbiter
  import mem_line_ctrl_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [N-1:0]            req_i,
  input  logic                    en_i,
  input  logic                    advance_i,
  output logic [N-1:0]            grant_o,
  output logic [idx_width(N)-1:0] grant_idx_o
);

  localparam int unsigned IW = idx_width(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    cand        = '0;
    found       = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      cand = IW'((int'(ptr_q) + i) % int'(N));
      if (en_i && !found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = IW'((int'(grant_idx_o) + 1) % int'(N));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_line_ctrl.sv
// Main-memory model serving whole cache lines to N requesters, one transaction at a time,
// with configurable request-side and response-side delays.
module mem_line_ctrl #(
  parameter int unsigned N_PORTS    = mem_line_ctrl_pkg::N_MEM_PORTS,
  parameter int unsigned LINE_LEN   = mem_line_ctrl_pkg::CACHE_LINE_LEN,
  parameter int unsigned ADDR_BITS  = mem_line_ctrl_pkg::MEM_ADDR_BITS,
  parameter int unsigned MEM_LINES  = mem_line_ctrl_pkg::MEM_LINES,
  parameter int unsigned REQ_DELAY  = mem_line_ctrl_pkg::MEM_REQ_DELAY,
  parameter int unsigned RESP_DELAY = mem_line_ctrl_pkg::MEM_RESP_DELAY
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_PORTS-1:0]            req_valid,
  output logic [N_PORTS-1:0]            req_ready,
  input  logic [N_PORTS-1:0]            req_we,
  input  logic [N_PORTS*ADDR_BITS-1:0]  req_addr,
  input  logic [N_PORTS*LINE_LEN-1:0]   req_wdata,
  output logic [N_PORTS-1:0]            resp_valid,
  output logic [LINE_LEN-1:0]           resp_data
);
  import mem_line_ctrl_pkg::*;

  localparam int unsigned OFF     = $clog2(LINE_LEN / 8);
  localparam int unsigned IDX_W   = $clog2(MEM_LINES);
  localparam int unsigned PW      = idx_width(N_PORTS);
  localparam int unsigned MAX_DLY = (REQ_DELAY > RESP_DELAY) ? REQ_DELAY : RESP_DELAY;
  localparam int unsigned CNT_W   = $clog2(MAX_DLY + 1) + 1;

  localparam logic [2:0] StIdle     = IDLE;
  localparam logic [2:0] StReqWait  = REQ_WAIT;
  localparam logic [2:0] StAccess   = ACCESS;
  localparam logic [2:0] StRespWait = RESP_WAIT;
  localparam logic [2:0] StResp     = RESP;

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q;
  logic [IDX_W-1:0]    idx_q;
  logic [LINE_LEN-1:0] wdata_q;
  logic [PW-1:0]       owner_q;
  logic [LINE_LEN-1:0] rdata_q;
  logic [LINE_LEN-1:0] mem_q [MEM_LINES];

  logic [N_PORTS-1:0]  grant;
  logic [PW-1:0]       grant_idx;
  logic                arb_en;
  logic                handshake;
  logic                sel_we;
  logic [IDX_W-1:0]    sel_idx;
  logic [LINE_LEN-1:0] sel_wdata;
  logic                unused_addr;

  // Offset and upper address bits are deliberately ignored so addresses wrap.
  assign unused_addr = ^req_addr;

  // Reset masks the grant so a request coinciding with reset is never accepted.
  assign arb_en    = (state_q == StIdle) && !reset;
  assign req_ready = grant;
  assign handshake = |(req_valid & grant);

  mem_line_ctrl_rr_arbiter #(
    .N (N_PORTS)
  ) u_arb (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_i       (req_valid),
    .en_i        (arb_en),
    .advance_i   (handshake),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_idx   = '0;
    sel_wdata = '0;
    for (int p = 0; p < int'(N_PORTS); p++) begin
      if (grant[p]) begin
        sel_we    = req_we[p];
        sel_idx   = req_addr[p*ADDR_BITS + OFF +: IDX_W];
        sel_wdata = req_wdata[p*LINE_LEN +: LINE_LEN];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (handshake) begin
          if (REQ_DELAY == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StReqWait;
            cnt_d   = CNT_W'(REQ_DELAY);
          end
        end
      end
      StReqWait: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (RESP_DELAY == 0) begin
          state_d = StResp;
        end else begin
          state_d = StRespWait;
          cnt_d   = CNT_W'(RESP_DELAY);
        end
      end
      StRespWait: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      owner_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (handshake) begin
        we_q    <= sel_we;
        idx_q   <= sel_idx;
        wdata_q <= sel_wdata;
        owner_q <= grant_idx;
      end
      // Writes echo the committed line back as their acknowledgement data.
      if (state_q == StAccess) begin
        rdata_q <= we_q ? wdata_q : mem_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (state_q == StAccess) && we_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign resp_valid = (state_q == StResp) ? (N_PORTS'(1) << owner_q) : '0;
  assign resp_data  = rdata_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Self-checking bench for mem_line_ctrl: default build plus a zero-delay build.
module tb_mem_line_ctrl;

  localparam int NP = 2;
  localparam int LL = 128;
  localparam int AB = 32;
  localparam int ML = 1024;
  localparam int RD = 5;
  localparam int SD = 5;
  localparam int LAT = RD + SD + 2;

  localparam logic [LL-1:0] DB   = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233;
  localparam logic [LL-1:0] AA   = {4{32'hAAAA_AAAA}};
  localparam logic [LL-1:0] P11  = {4{32'h1111_1111}};
  localparam logic [LL-1:0] P55  = {4{32'h5555_5555}};
  localparam logic [LL-1:0] P99  = {4{32'h9999_9999}};
  localparam logic [LL-1:0] PA   = {4{32'h0A0A_0A0A}};
  localparam logic [LL-1:0] PB   = {4{32'h0B0B_0B0B}};
  localparam logic [LL-1:0] ZPAT = {4{32'hC3C3_3C3C}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NP-1:0]     req_valid, req_ready, req_we, resp_valid;
  logic [NP*AB-1:0]  req_addr;
  logic [NP*LL-1:0]  req_wdata;
  logic [LL-1:0]     resp_data;

  logic [NP-1:0]     z_req_valid, z_req_ready, z_req_we, z_resp_valid;
  logic [NP*AB-1:0]  z_req_addr;
  logic [NP*LL-1:0]  z_req_wdata;
  logic [LL-1:0]     z_resp_data;

  mem_line_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

  mem_line_ctrl #(
    .REQ_DELAY  (0),
    .RESP_DELAY (0)
  ) dut_z (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (z_req_valid),
    .req_ready  (z_req_ready),
    .req_we     (z_req_we),
    .req_addr   (z_req_addr),
    .req_wdata  (z_req_wdata),
    .resp_valid (z_resp_valid),
    .resp_data  (z_resp_data)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory: whole lines indexed by (byte address / 16) mod depth.
  logic [LL-1:0] mdl  [ML];
  bit            mval [ML];

  function automatic int line_of(input logic [AB-1:0] a);
    return int'((a >> 4) % ML);
  endfunction

  task automatic check(input string name, input logic [LL-1:0] act, input logic [LL-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One complete transaction on the default DUT, starting just after a negedge.
  task automatic txn(input logic [0:0] pi, input logic we, input logic [AB-1:0] addr,
                     input logic [LL-1:0] wd, output logic [LL-1:0] rd, output int lat);
    int t0;
    int n;
    req_we[pi]             = we;
    req_addr[pi*AB +: AB]  = addr;
    req_wdata[pi*LL +: LL] = wd;
    req_valid[pi]          = 1'b1;
    #1;
    n = 0;
    while (!req_ready[pi] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("accept", LL'(req_ready[pi]), LL'(1));
    t0 = cyc;
    @(negedge clk);
    req_valid[pi] = 1'b0;
    #1;
    n = 0;
    while (resp_valid == '0 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("resp_owner", LL'(resp_valid), LL'(2'b01 << pi));
    lat = cyc - t0;
    rd  = resp_data;
    @(negedge clk); #1;
    check("resp_pulse", LL'(resp_valid), '0);
  endtask

  typedef struct {
    logic [0:0]    port;
    logic          we;
    logic [AB-1:0] addr;
    logic [LL-1:0] wdata;
    logic [LL-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LL-1:0] rd;
    logic [LL-1:0] exp;
    logic [AB-1:0] addr;
    logic [0:0]    pi;
    logic          we;
    logic [LL-1:0] wd;
    logic [NP-1:0] r_seen;
    int            lat;
    int            idx;
    int            n;
    int            cnt0;
    int            cnt1;
    int            acc[$];
    int            rsp[$];

    for (int i = 0; i < ML; i++) mval[i] = 1'b0;

    // Both ports already requesting while reset is held: nothing may be accepted.
    reset       = 1'b1;
    req_we      = 2'b11;
    req_addr    = {32'h0000_0200, 32'h0000_0100};
    req_wdata   = {PB, PA};
    req_valid   = 2'b11;
    z_req_valid = '0;
    z_req_we    = '0;
    z_req_addr  = '0;
    z_req_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", LL'(req_ready), '0);
    check("rst_resp_valid", LL'(resp_valid), '0);
    check("rst_resp_data", resp_data, '0);
    check("rst_z_resp_data", z_resp_data, '0);

    // Arbitration: port0 first, then port1 despite port0 re-requesting, then port0.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arb_first", LL'(req_ready), LL'(2'b01));
    @(negedge clk); #1;
    r_seen = '0;
    n = 0;
    while (req_ready == '0 && n < 40) begin
      if (resp_valid != '0) begin
        r_seen = resp_valid;
        check("arb_echo0", resp_data, PA);
      end
      @(negedge clk); #1; n++;
    end
    check("arb_resp_owner0", LL'(r_seen), LL'(2'b01));
    check("arb_second", LL'(req_ready), LL'(2'b10));
    @(negedge clk); #1;
    r_seen = '0;
    n = 0;
    while (req_ready == '0 && n < 40) begin
      if (resp_valid != '0) r_seen = resp_valid;
      @(negedge clk); #1; n++;
    end
    check("arb_resp_owner1", LL'(r_seen), LL'(2'b10));
    check("arb_third", LL'(req_ready), LL'(2'b01));
    @(negedge clk);
    req_valid = '0;
    #1;
    n = 0;
    while (resp_valid == '0 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    check("arb_resp_owner2", LL'(resp_valid), LL'(2'b01));
    @(negedge clk);
    mdl[line_of(32'h100)] = PA; mval[line_of(32'h100)] = 1'b1;
    mdl[line_of(32'h200)] = PB; mval[line_of(32'h200)] = 1'b1;

    // Zero-delay build: accept every 3 cycles, respond 2 cycles after accept.
    z_req_we    = 2'b01;
    z_req_addr  = {32'h0, 32'h40};
    z_req_wdata = {LL'(0), ZPAT};
    z_req_valid = 2'b01;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (z_req_ready[0]) acc.push_back(cyc);
      if (z_resp_valid[0]) begin
        rsp.push_back(cyc);
        check("z_echo", z_resp_data, ZPAT);
      end
      @(negedge clk);
    end
    z_req_valid = '0;
    check("z_acc_count", LL'(acc.size()), LL'(4));
    check("z_rsp_count", LL'(rsp.size()), LL'(4));
    for (int i = 1; i < acc.size(); i++) check("z_acc_gap", LL'(acc[i] - acc[i-1]), LL'(3));
    for (int i = 0; i < rsp.size() && i < acc.size(); i++)
      check("z_lat", LL'(rsp[i] - acc[i]), LL'(2));

    // Directed single transactions, including wrap-around and ignored offset bits.
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0040, DB,  DB});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_0040, '0,  DB});
    vecs.push_back('{1'b1, 1'b1, 32'h0000_0040, AA,  AA});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_4040, '0,  AA});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_004F, '0,  AA});
    vecs.push_back('{1'b1, 1'b1, 32'h0000_0080, P11, P11});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0080, '0,  P11});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_0100, '0,  PA});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0200, '0,  PB});
    foreach (vecs[i]) begin
      txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      check($sformatf("vec%0d_data", i), rd, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), LL'(lat), LL'(LAT));
      if (vecs[i].we) begin
        mdl[line_of(vecs[i].addr)]  = vecs[i].wdata;
        mval[line_of(vecs[i].addr)] = 1'b1;
      end
    end

    // Port1 pulses req_valid while port0 owns a read: no grant, no latch, no response.
    req_we[0] = 1'b0; req_addr[0 +: AB] = 32'h80; req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("hold_accept", LL'(req_ready[0]), LL'(1));
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_we[1] = 1'b1; req_addr[AB +: AB] = 32'h80; req_wdata[LL +: LL] = P99; req_valid[1] = 1'b1;
    #1;
    check("hold_p1_ready_a", LL'(req_ready), '0);
    @(negedge clk); #1;
    check("hold_p1_ready_b", LL'(req_ready), '0);
    req_valid[1] = 1'b0;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid[0]) begin
        cnt0++;
        check("hold_p0_data", resp_data, P11);
      end
      if (resp_valid[1]) cnt1++;
      @(negedge clk); #1;
    end
    check("hold_p0_resps", LL'(cnt0), LL'(1));
    check("hold_p1_resps", LL'(cnt1), '0);
    @(negedge clk);
    txn(1'b1, 1'b0, 32'h80, '0, rd, lat);
    check("hold_not_latched", rd, P11);

    // Reset during REQ_WAIT drops the write and its response.
    req_we[0] = 1'b1; req_addr[0 +: AB] = 32'h80; req_wdata[0 +: LL] = P55; req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("mid_rst_accept", LL'(req_ready[0]), LL'(1));
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    cnt0 = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid != '0) cnt0++;
      @(negedge clk); #1;
    end
    check("mid_rst_no_resp", LL'(cnt0), '0);
    @(negedge clk);
    txn(1'b0, 1'b0, 32'h80, '0, rd, lat);
    check("mid_rst_not_committed", rd, P11);
    check("mid_rst_lat", LL'(lat), LL'(LAT));

    // Random traffic over a few lines with random upper/offset bits.
    for (int i = 0; i < 40; i++) begin
      pi   = 1'($urandom_range(0, 1));
      addr = ($urandom & 32'hFFFF_C00F) | (32'($urandom_range(0, 15)) << 4);
      idx  = line_of(addr);
      we   = mval[idx] ? 1'($urandom_range(0, 1)) : 1'b1;
      wd   = {$urandom, $urandom, $urandom, $urandom};
      txn(pi, we, addr, wd, rd, lat);
      exp = we ? wd : mdl[idx];
      if (we) begin
        mdl[idx]  = wd;
        mval[idx] = 1'b1;
      end
      check($sformatf("rnd%0d_data", i), rd, exp);
      check($sformatf("rnd%0d_lat", i), LL'(lat), LL'(LAT));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
